// File: rtl/ysyx_25040109_arbiter.sv
// Two-master AXI-lite arbiter: the IFU (read-only) and the LSU (read/write)
// share one downstream port. One transaction is in flight at a time.
// Writes take priority over reads. Read ties alternate using last_rd.
module ysyx_25040109_arbiter (
    input  logic        clk,
    input  logic        rst,
    // master 0 (IFU) read channels
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    // master 1 (LSU) read channels
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    // master 1 (LSU) write channels
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,
    // downstream port
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [31:0] out_araddr,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    output logic        out_awvalid,
    input  logic        out_awready,
    output logic [31:0] out_awaddr,
    output logic        out_wvalid,
    input  logic        out_wready,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    input  logic        out_bvalid,
    output logic        out_bready,
    input  logic [1:0]  out_bresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_B    = 2'd3
    } arb_state_t;

    arb_state_t state_r, state_nxt_s;
    logic       rd_owner_r, rd_owner_nxt_s;
    logic       last_rd_r, last_rd_nxt_s;
    logic       ar_done_r, ar_done_nxt_s;
    logic       aw_done_r, aw_done_nxt_s;
    logic       w_done_r, w_done_nxt_s;

    logic        own_arvalid_s;
    logic [31:0] own_araddr_s;
    logic        own_rready_s;
    logic        aw_hs_s;
    logic        w_hs_s;

    // Read data and response are broadcast; only rvalid selects the owner.
    assign m0_rdata = out_rdata;
    assign m0_rresp = out_rresp;
    assign m1_rdata = out_rdata;
    assign m1_rresp = out_rresp;
    assign m1_bresp = out_bresp;

    // Signals of whichever master currently owns the read.
    assign own_arvalid_s = rd_owner_r ? m1_arvalid : m0_arvalid;
    assign own_araddr_s  = rd_owner_r ? m1_araddr  : m0_araddr;
    assign own_rready_s  = rd_owner_r ? m1_rready  : m0_rready;

    // A write handshake counts only while that channel is still open in WR.
    assign aw_hs_s = (state_r == ST_WR) && !aw_done_r && m1_awvalid && out_awready;
    assign w_hs_s  = (state_r == ST_WR) && !w_done_r  && m1_wvalid  && out_wready;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rd_owner_r <= 1'b0;
            last_rd_r  <= 1'b1;
            ar_done_r  <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rd_owner_r <= rd_owner_nxt_s;
            last_rd_r  <= last_rd_nxt_s;
            ar_done_r  <= ar_done_nxt_s;
            aw_done_r  <= aw_done_nxt_s;
            w_done_r   <= w_done_nxt_s;
        end
    end

    // Next-state selection and channel routing for the current owner.
    always_comb begin
        state_nxt_s    = state_r;
        rd_owner_nxt_s = rd_owner_r;
        last_rd_nxt_s  = last_rd_r;
        ar_done_nxt_s  = ar_done_r;
        aw_done_nxt_s  = aw_done_r;
        w_done_nxt_s   = w_done_r;

        m0_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_arready  = 1'b0;
        m1_rvalid   = 1'b0;
        m1_awready  = 1'b0;
        m1_wready   = 1'b0;
        m1_bvalid   = 1'b0;
        out_arvalid = 1'b0;
        out_araddr  = 32'h0000_0000;
        out_rready  = 1'b0;
        out_awvalid = 1'b0;
        out_awaddr  = 32'h0000_0000;
        out_wvalid  = 1'b0;
        out_wdata   = 32'h0000_0000;
        out_wstrb   = 4'b0000;
        out_bready  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (m1_awvalid) begin
                    state_nxt_s = ST_WR;
                end else if (m0_arvalid && m1_arvalid) begin
                    state_nxt_s    = ST_RD;
                    rd_owner_nxt_s = ~last_rd_r;
                end else if (m0_arvalid) begin
                    state_nxt_s    = ST_RD;
                    rd_owner_nxt_s = 1'b0;
                end else if (m1_arvalid) begin
                    state_nxt_s    = ST_RD;
                    rd_owner_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (!ar_done_r) begin
                    out_arvalid = own_arvalid_s;
                    out_araddr  = own_araddr_s;
                    if (rd_owner_r) begin
                        m1_arready = out_arready;
                    end else begin
                        m0_arready = out_arready;
                    end
                    if (own_arvalid_s && out_arready) begin
                        ar_done_nxt_s = 1'b1;
                    end else begin
                        ar_done_nxt_s = 1'b0;
                    end
                end else begin
                    out_rready = own_rready_s;
                    if (rd_owner_r) begin
                        m1_rvalid = out_rvalid;
                    end else begin
                        m0_rvalid = out_rvalid;
                    end
                    if (out_rvalid && own_rready_s) begin
                        state_nxt_s   = ST_IDLE;
                        last_rd_nxt_s = rd_owner_r;
                        ar_done_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (!aw_done_r) begin
                    out_awvalid = m1_awvalid;
                    out_awaddr  = m1_awaddr;
                    m1_awready  = out_awready;
                end else begin
                    out_awvalid = 1'b0;
                end
                if (!w_done_r) begin
                    out_wvalid = m1_wvalid;
                    out_wdata  = m1_wdata;
                    out_wstrb  = m1_wstrb;
                    m1_wready  = out_wready;
                end else begin
                    out_wvalid = 1'b0;
                end
                aw_done_nxt_s = aw_done_r | aw_hs_s;
                w_done_nxt_s  = w_done_r | w_hs_s;
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                    state_nxt_s = ST_B;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_B: begin
                m1_bvalid  = out_bvalid;
                out_bready = m1_bready;
                if (out_bvalid && m1_bready) begin
                    state_nxt_s   = ST_IDLE;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_arbiter.sv
// Directed bench for the IFU/LSU arbiter: a downstream slave model answers
// transactions, expected responses are queued as stimulus is issued, and a
// monitor pops and compares whenever a handshake is presented.
module tb_ysyx_25040109_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        out_arvalid, out_arready, out_rvalid, out_rready;
    logic [31:0] out_araddr, out_rdata;
    logic [1:0]  out_rresp;
    logic        out_awvalid, out_awready, out_wvalid, out_wready, out_bvalid, out_bready;
    logic [31:0] out_awaddr, out_wdata;
    logic [3:0]  out_wstrb;
    logic [1:0]  out_bresp;

    always #5 clk = ~clk;

    ysyx_25040109_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
        .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
        .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
        .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
        .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
    } grant_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    grant_t      exp_grant[$];
    logic [35:0] exp_w[$];
    logic [33:0] exp_r0[$];
    logic [33:0] exp_r1[$];
    logic [1:0]  exp_b1[$];
    logic [33:0] slv_r[$];
    logic [1:0]  slv_bresp = 2'b00;
    int          aw_wait = 0;
    int          w_wait = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic note_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=no/unexpected event required=expected event", nm);
    endtask

    function automatic logic [63:0] ctl_vec();
        return {52'd0, out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready,
                m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
    endfunction

    // Monitor: compare every handshake against the scoreboard queues.
    initial begin
        grant_t g;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_arvalid && out_arready) begin
                    if (exp_grant.size() == 0) note_fail("ar_unexpected");
                    else begin g = exp_grant.pop_front(); chk("ar_grant", {31'd0, 1'b0, out_araddr}, {31'd0, g}); end
                end
                if (out_awvalid && out_awready) begin
                    if (exp_grant.size() == 0) note_fail("aw_unexpected");
                    else begin g = exp_grant.pop_front(); chk("aw_grant", {31'd0, 1'b1, out_awaddr}, {31'd0, g}); end
                end
                if (out_wvalid && out_wready) begin
                    if (exp_w.size() == 0) note_fail("w_unexpected");
                    else chk("w_data", {28'd0, out_wstrb, out_wdata}, {28'd0, exp_w.pop_front()});
                end
                if (m0_rvalid && m0_rready) begin
                    if (exp_r0.size() == 0) note_fail("m0_r_unexpected");
                    else chk("m0_r", {30'd0, m0_rresp, m0_rdata}, {30'd0, exp_r0.pop_front()});
                end
                if (m1_rvalid && m1_rready) begin
                    if (exp_r1.size() == 0) note_fail("m1_r_unexpected");
                    else chk("m1_r", {30'd0, m1_rresp, m1_rdata}, {30'd0, exp_r1.pop_front()});
                end
                if (m1_bvalid && m1_bready) begin
                    if (exp_b1.size() == 0) note_fail("m1_b_unexpected");
                    else chk("m1_b", {62'd0, m1_bresp}, {62'd0, exp_b1.pop_front()});
                end
                chk("isolation", {63'd0, (m0_arready | m0_rvalid) &
                    (m1_arready | m1_rvalid | m1_awready | m1_wready | m1_bvalid)}, 64'd0);
            end
        end
    end

    // Downstream slave model: AR always ready, R two cycles after AR,
    // AW/W ready after a programmable wait, B once both AW and W arrived.
    initial begin
        logic arhs, rhs, awv, awhs, wv, whs, bhs, r_pend, aw_got, w_got;
        logic [33:0] rsp;
        int aw_cnt, w_cnt;
        out_arready = 1'b1; out_rvalid = 1'b0; out_rdata = 32'h0; out_rresp = 2'b00;
        out_awready = 1'b0; out_wready = 1'b0; out_bvalid = 1'b0; out_bresp = 2'b00;
        r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(negedge clk);
            arhs = out_arvalid & out_arready;
            rhs  = out_rvalid & out_rready;
            awv  = out_awvalid; awhs = out_awvalid & out_awready;
            wv   = out_wvalid;  whs  = out_wvalid & out_wready;
            bhs  = out_bvalid & out_bready;
            @(posedge clk);
            #1;
            if (!rst) begin
                out_rvalid = 1'b0; out_awready = 1'b0; out_wready = 1'b0; out_bvalid = 1'b0;
                r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
                slv_r.delete();
            end else begin
                if (rhs) out_rvalid = 1'b0;
                if (arhs) r_pend = 1'b1;
                else if (r_pend) begin
                    rsp = (slv_r.size() != 0) ? slv_r.pop_front() : {2'b00, 32'hDEAD_BEEF};
                    out_rvalid = 1'b1; out_rresp = rsp[33:32]; out_rdata = rsp[31:0];
                    r_pend = 1'b0;
                end
                if (awhs) begin out_awready = 1'b0; aw_cnt = 0; aw_got = 1'b1; end
                else if (awv) begin aw_cnt++; out_awready = (aw_cnt > aw_wait); end
                else out_awready = 1'b0;
                if (whs) begin out_wready = 1'b0; w_cnt = 0; w_got = 1'b1; end
                else if (wv) begin w_cnt++; out_wready = (w_cnt > w_wait); end
                else out_wready = 1'b0;
                if (bhs) out_bvalid = 1'b0;
                if (aw_got && w_got) begin
                    out_bvalid = 1'b1; out_bresp = slv_bresp; aw_got = 1'b0; w_got = 1'b0;
                end
            end
        end
    end

    task automatic m0_ar(input logic [31:0] a);
        logic hs;
        hs = 1'b0; m0_araddr = a; m0_arvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk); hs = m0_arready; @(posedge clk); #1;
        end
        m0_arvalid = 1'b0;
        if (!hs) note_fail("m0_ar_timeout");
    endtask

    task automatic m1_ar(input logic [31:0] a);
        logic hs;
        hs = 1'b0; m1_araddr = a; m1_arvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk); hs = m1_arready; @(posedge clk); #1;
        end
        m1_arvalid = 1'b0;
        if (!hs) note_fail("m1_ar_timeout");
    endtask

    task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int aw_at, output int w_at);
        logic awd, wd, awh, wh;
        awd = 1'b0; wd = 1'b0; aw_at = -1; w_at = -1;
        m1_awaddr = a; m1_awvalid = 1'b1; m1_wdata = d; m1_wstrb = s; m1_wvalid = 1'b1;
        for (int i = 0; i < 100 && !(awd && wd); i++) begin
            @(negedge clk);
            awh = m1_awvalid & m1_awready; wh = m1_wvalid & m1_wready;
            @(posedge clk); #1;
            if (awh) begin m1_awvalid = 1'b0; awd = 1'b1; aw_at = i; end
            if (wh)  begin m1_wvalid = 1'b0;  wd = 1'b1;  w_at = i; end
        end
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        if (!(awd && wd)) note_fail("m1_write_timeout");
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            done = (exp_grant.size() + exp_w.size() + exp_r0.size() + exp_r1.size() + exp_b1.size()) == 0;
            if (!done) begin @(posedge clk); #1; end
        end
        if (!done) note_fail("drain_timeout");
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int aw_at, w_at;
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int aw_at, w_at;
        rst = 1'b0;
        m0_arvalid = 1'b0; m0_araddr = 32'h0; m0_rready = 1'b1;
        m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_rready = 1'b1;
        m1_awvalid = 1'b0; m1_awaddr = 32'h0; m1_wvalid = 1'b0; m1_wdata = 32'h0;
        m1_wstrb = 4'b0000; m1_bready = 1'b1;
        #12;
        chk("reset_outs", ctl_vec(), 64'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", ctl_vec(), 64'd0);

        // Tie straight after reset: m0 wins, then m1.
        exp_grant.push_back({1'b0, 32'h8000_0100}); exp_grant.push_back({1'b0, 32'h8000_0200});
        slv_r.push_back({2'b00, 32'h1111_1111});    slv_r.push_back({2'b00, 32'h2222_2222});
        exp_r0.push_back({2'b00, 32'h1111_1111});   exp_r1.push_back({2'b00, 32'h2222_2222});
        fork
            m0_ar(32'h8000_0100);
            m1_ar(32'h8000_0200);
        join
        wait_idle();

        // Lone m0 fetch: grant one cycle after request, m1 untouched.
        exp_grant.push_back({1'b0, 32'h8000_0000});
        slv_r.push_back({2'b00, 32'h0000_0013});
        exp_r0.push_back({2'b00, 32'h0000_0013});
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        #1;
        chk("grant_cycle0", {63'd0, out_arvalid}, 64'd0);
        @(posedge clk); #1;
        chk("grant_cycle1", {31'd0, out_arvalid, out_araddr}, {31'd0, 1'b1, 32'h8000_0000});
        chk("m1_quiet", {62'd0, m1_arready, m1_rvalid}, 64'd0);
        m0_ar(32'h8000_0000);
        wait_idle();

        // Tie with last_rd = m0: m1 goes first this time.
        exp_grant.push_back({1'b0, 32'h8000_0400}); exp_grant.push_back({1'b0, 32'h8000_0300});
        slv_r.push_back({2'b00, 32'h4444_4444});    slv_r.push_back({2'b00, 32'h3333_3333});
        exp_r1.push_back({2'b00, 32'h4444_4444});   exp_r0.push_back({2'b00, 32'h3333_3333});
        fork
            m0_ar(32'h8000_0300);
            m1_ar(32'h8000_0400);
        join
        wait_idle();

        // Write beats a simultaneous m0 read.
        exp_grant.push_back({1'b1, 32'h1000_0000}); exp_grant.push_back({1'b0, 32'h8000_0004});
        exp_w.push_back({4'b0001, 32'h0000_0041});
        slv_bresp = 2'b00; exp_b1.push_back(2'b00);
        slv_r.push_back({2'b00, 32'hAAAA_0001});    exp_r0.push_back({2'b00, 32'hAAAA_0001});
        fork
            m1_write(32'h1000_0000, 32'h0000_0041, 4'b0001, aw_at, w_at);
            m0_ar(32'h8000_0004);
        join
        wait_idle();

        // m1 read pending behind its own write; SLVERR on B passes through.
        exp_grant.push_back({1'b1, 32'h1000_0010}); exp_grant.push_back({1'b0, 32'h8000_1000});
        exp_w.push_back({4'b1111, 32'hCAFE_F00D});
        slv_bresp = 2'b10; exp_b1.push_back(2'b10);
        slv_r.push_back({2'b01, 32'h5555_AAAA});    exp_r1.push_back({2'b01, 32'h5555_AAAA});
        fork
            m1_write(32'h1000_0010, 32'hCAFE_F00D, 4'b1111, aw_at, w_at);
            m1_ar(32'h8000_1000);
        join
        wait_idle();

        // W completes three cycles before AW: exactly one B.
        aw_wait = 3; w_wait = 0; slv_bresp = 2'b00;
        exp_grant.push_back({1'b1, 32'h1000_0020});
        exp_w.push_back({4'b0011, 32'h0000_1234});
        exp_b1.push_back(2'b00);
        m1_write(32'h1000_0020, 32'h0000_1234, 4'b0011, aw_at, w_at);
        chk("w_before_aw", 64'(aw_at - w_at), 64'd3);
        wait_idle();
        aw_wait = 0;

        // DECERR on an m1 read is forwarded, then a new read proceeds.
        exp_grant.push_back({1'b0, 32'h8000_2000});
        slv_r.push_back({2'b11, 32'h0000_0000});    exp_r1.push_back({2'b11, 32'h0000_0000});
        m1_ar(32'h8000_2000);
        wait_idle();
        exp_grant.push_back({1'b0, 32'h8000_2004});
        slv_r.push_back({2'b00, 32'h0000_0077});    exp_r0.push_back({2'b00, 32'h0000_0077});
        m0_ar(32'h8000_2004);
        wait_idle();

        // Reset during the R phase abandons the read silently.
        exp_grant.push_back({1'b0, 32'h8000_3000});
        slv_r.push_back({2'b00, 32'h0000_0099});
        m1_ar(32'h8000_3000);
        #3;
        chk("rphase_rready", {63'd0, out_rready}, 64'd1);
        rst = 1'b0;
        #1;
        chk("reset_mid_outs", ctl_vec(), 64'd0);
        repeat (2) @(posedge clk);
        #3; rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", ctl_vec(), 64'd0);
        exp_grant.push_back({1'b0, 32'h8000_3004});
        slv_r.push_back({2'b00, 32'h0000_BEEF});    exp_r1.push_back({2'b00, 32'h0000_BEEF});
        m1_ar(32'h8000_3004);
        wait_idle();

        chk("queues_drained", 64'(exp_grant.size() + exp_w.size() + exp_r0.size()
                                  + exp_r1.size() + exp_b1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
